simple_pipe: RTL
================

# simple_pipe

Parametrised, pipelined successor to the single-bit `simple` logic cell.
- Applies one of four selectable two-input logic functions bitwise across `WIDTH` lanes.
- Registers the result through `STAGES` pipeline slices with valid/ready backpressure.
- Counts completed output transfers.
- Sits between netlist-enhancer test sources and sinks as a reusable, timing-closed logic datapath.

## Interface
Parameters:
- `WIDTH`, default 8: lanes per operand; must be ≥1.
- `STAGES`, default 2: register slices from input to `out`; must be ≥1.

Ports:
- `iccad_clk`  in  1  sole clock; all state updates on its rising edge.
- `iccad_rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  input beat present.
- `in_ready`  out  1  block accepts the beat this cycle.
- `op`  in  2  function select, sampled with the beat.
- `inp1`  in  `WIDTH`  operand A.
- `inp2`  in  `WIDTH`  operand B.
- `out_valid`  out  1  result beat present.
- `out_ready`  in  1  sink accepts the result.
- `out`  out  `WIDTH`  result.
- `xfer_cnt`  out  16  number of output transfers.
- `out_par`  out  1  even parity of `out`. Present only with `SIMPLE_PIPE_PARITY_EN`.

## Operation
- Lane function, applied before slice 0 and registered there:
  - `op`=0 NAND: `~(inp1&inp2)`.
  - `op`=1 NOR: `~(inp1|inp2)`.
  - `op`=2 XOR: `inp1^inp2`.
  - `op`=3 XNOR: `~(inp1^inp2)`.
- Each slice k holds `v[k]` and `d[k]`.
- Slice k advances when `~v[k+1] | adv[k+1]`. The last slice advances when `out_ready`.
- `in_ready` = `~iccad_rst & (~v[0] | adv[0])`. Bubbles collapse.
- Input transfer: `in_valid & in_ready`. Output transfer: `out_valid & out_ready`.
- `out_valid` = `v[STAGES-1]`. `out` = `d[STAGES-1]`.
- `xfer_cnt` increments by 1 per output transfer. It wraps from 0xFFFF to 0x0000 with no flag.
- Reset values: all `v` = 0, all `d` = 0, `out` = 0, `out_valid` = 0, `xfer_cnt` = 0, `out_par` = 0. `in_ready` = 0 while `iccad_rst` is high.
- Reset mid-operation: in-flight beats are discarded, with no partial output.
- A full pipe with `out_ready` high accepts a new input in the same cycle it emits.
- `op` values are fully decoded; there is no illegal encoding.

## Timing
- Latency: an input accepted at edge t appears with `out_valid`=1 after edge t+STAGES-1, i.e. visible in cycle t+STAGES. This holds with no backpressure.
- Throughput: 1 beat/cycle sustained while `out_ready`=1.
- While `out_valid & ~out_ready`, `out` and `out_par` are held stable. Beats are never dropped or duplicated.
- Capacity: STAGES beats. `in_ready` falls in the cycle where all slices are valid and `out_ready`=0.
- `in_ready` depends combinationally on `out_ready`. This is the documented ready path of depth STAGES.
- `xfer_cnt` updates at the edge that completes the transfer.

## Configuration
- Macro: `SIMPLE_PIPE_PARITY_EN`.
- Defined:
  - Each slice carries one extra bit equal to `^result`, computed at slice 0.
  - `out_par` is an output, registered in step with `out`.
- Undefined:
  - The `out_par` port and the parity bits do not exist.
  - All other behaviour is identical.

## Structure
- Package `simple_pkg`:
  - `op_e` enum: `OP_NAND`=0, `OP_NOR`=1, `OP_XOR`=2, `OP_XNOR`=3.
  - Function `lane_op(op, a, b)`.
  - Localparam `CNT_W`=16.
- Sub-module `simple_stage`:
  - One valid/ready register slice, parametrised by payload width.
  - Instantiated STAGES times in a generate loop.

## Test plan
1. Reset held 3 cycles with `in_valid`=1, then released: `in_ready`=0, `out_valid`=0, `out`=0x00 and `xfer_cnt`=0 during reset; `in_ready`=1 in the cycle after release.
2. WIDTH=8, STAGES=2, `out_ready`=1, `inp1`=0xF0, `inp2`=0xCC, `op`=0,1,2,3 on consecutive cycles: `out` = 0x3F, 0x03, 0x3C, 0xC3 on consecutive cycles, first result 2 cycles after acceptance. `xfer_cnt`=4 afterwards. With the macro, `out_par` = 0,0,0,0.
3. `out_ready`=0 with 3 beats offered: 2 accepted, `in_ready`=0, and `out` holds 0x3F. Raise `out_ready`: both beats emerge in order, and the third beat is accepted in the same cycle as the first emit.
4. Random `in_valid`/`out_ready` patterns, 1000 beats: output sequence equals reference-model `lane_op` order, with no loss or duplication. `xfer_cnt`=1000.
5. Preload `xfer_cnt` to 0xFFFE via 65534 transfers, then 3 more: `xfer_cnt` reads 0xFFFF, 0x0000, 0x0001.
6. Assert `iccad_rst` for 1 cycle with 2 beats in flight: `out_valid`=0 next cycle, no stale beat emerges, and `xfer_cnt`=0.

Source files
------------

// File: rtl/simple_pkg.sv
// simple_pkg: shared op encoding, lane function and counter width for simple_pipe.
package simple_pkg;
  localparam int CNT_W = 16;
  typedef enum logic [1:0] {
    OP_NAND = 2'd0,
    OP_NOR  = 2'd1,
    OP_XOR  = 2'd2,
    OP_XNOR = 2'd3
  } op_e;
  function automatic logic lane_op(op_e op, logic a, logic b);
    return op == OP_NAND ? ~(a & b) :
           op == OP_NOR  ? ~(a | b) :
           op == OP_XOR  ? a ^ b    : ~(a ^ b);
  endfunction
endpackage

// File: rtl/simple_stage.sv
// simple_stage: one valid/ready register slice; bubbles collapse because an empty slice always accepts.
module simple_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  output logic         ready_o,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  input  logic         ready_i
);
  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;
  assign ready_o = ~valid_q | ready_i;
  always_comb begin
    valid_d = ready_o ? valid_i : valid_q;
    data_d  = (ready_o & valid_i) ? data_i : data_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end
  assign valid_o = valid_q;
  assign data_o  = data_q;
endmodule

// File: rtl/simple_pipe.sv
// simple_pipe: bitwise two-input logic function over WIDTH lanes, pipelined through STAGES slices.
// Optional SIMPLE_PIPE_PARITY_EN carries an even-parity bit alongside each result.
module simple_pipe
  import simple_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             iccad_clk,
  input  logic             iccad_rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] inp1,
  input  logic [WIDTH-1:0] inp2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
`ifdef SIMPLE_PIPE_PARITY_EN
  output logic             out_par,
`endif
  output logic [15:0]      xfer_cnt
);
`ifdef SIMPLE_PIPE_PARITY_EN
  localparam int PW = WIDTH + 1;
`else
  localparam int PW = WIDTH;
`endif
  logic [WIDTH-1:0] res;
  logic             vld [STAGES+1];
  logic             rdy [STAGES+1];
  logic [PW-1:0]    dat [STAGES+1];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb begin
    res = '0;
    for (int i = 0; i < WIDTH; i++) res[i] = lane_op(op_e'(op), inp1[i], inp2[i]);
  end
  assign vld[0]      = in_valid;
  assign rdy[STAGES] = out_ready;
`ifdef SIMPLE_PIPE_PARITY_EN
  assign dat[0]  = {^res, res};
  assign out_par = dat[STAGES][WIDTH];
`else
  assign dat[0]  = res;
`endif
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    simple_stage #(.W(PW)) u_stage (
      .clk    (iccad_clk),
      .rst    (iccad_rst),
      .valid_i(vld[k]),
      .data_i (dat[k]),
      .ready_o(rdy[k]),
      .valid_o(vld[k+1]),
      .data_o (dat[k+1]),
      .ready_i(rdy[k+1])
    );
  end
  assign in_ready  = ~iccad_rst & rdy[0];
  assign out_valid = vld[STAGES];
  assign out       = dat[STAGES][WIDTH-1:0];
  always_comb cnt_d = (out_valid & out_ready) ? cnt_q + CNT_W'(1) : cnt_q;
  always_ff @(posedge iccad_clk) begin
    if (iccad_rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign xfer_cnt = cnt_q;
endmodule
